// File: rtl/issue_pipe_pkg.sv
// Shared types for the issue stage: ID->IS and IS->EX packets and issue state.
// Also hosts the operand bypass and the packet translation helpers.
package issue_pipe_pkg;

    localparam int XLEN            = 32;
    localparam int PHYS_REG_IDX_SZ = 5;
    localparam int ROB_IDX_SZ      = 4;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } issue_state_e;

    typedef struct packed {
        logic [PHYS_REG_IDX_SZ:0] reg_num;
    } phys_reg_t;

    typedef struct packed {
        logic [31:0]           inst;
        logic [XLEN-1:0]       PC;
        logic [XLEN-1:0]       NPC;
        logic [1:0]            opa_select;
        logic [3:0]            opb_select;
        phys_reg_t             src1_reg;
        phys_reg_t             src2_reg;
        phys_reg_t             dest_reg;
        logic [4:0]            alu_func;
        logic                  rd_mem;
        logic                  wr_mem;
        logic                  cond_branch;
        logic                  uncond_branch;
        logic                  halt;
        logic                  illegal;
        logic                  csr_op;
        logic [2:0]            function_type;
        logic [ROB_IDX_SZ-1:0] rob_index;
        logic                  has_dest;
        logic [1:0]            issued_fu_index;
        logic [4:0]            arch_dest_reg_num;
    } ID_IS_PACKET;

    typedef struct packed {
        logic                     valid;
        logic [31:0]              inst;
        logic [XLEN-1:0]          PC;
        logic [XLEN-1:0]          NPC;
        logic [XLEN-1:0]          rs1_value;
        logic [XLEN-1:0]          rs2_value;
        logic [1:0]               opa_select;
        logic [3:0]               opb_select;
        logic [PHYS_REG_IDX_SZ:0] dest_reg_idx;
        logic [4:0]               alu_func;
        logic                     rd_mem;
        logic                     wr_mem;
        logic                     cond_branch;
        logic                     uncond_branch;
        logic                     halt;
        logic                     illegal;
        logic                     csr_op;
        logic [2:0]               function_type;
        logic [ROB_IDX_SZ-1:0]    rob_index;
        logic                     has_dest;
        logic [1:0]               issued_fu_index;
        logic [4:0]               arch_dest_reg_num;
    } IS_EX_PACKET;

    // Physical reg 0 is hardwired zero, so a broadcast to it never forwards.
    function automatic logic [XLEN-1:0] bypass(
        input logic                     cdb_valid,
        input logic [PHYS_REG_IDX_SZ:0] cdb_tag,
        input logic [XLEN-1:0]          cdb_data,
        input logic [PHYS_REG_IDX_SZ:0] reg_num,
        input logic [XLEN-1:0]          rf_data
    );
        logic hit;
        hit = cdb_valid && (cdb_tag == reg_num) && (reg_num != '0);
        return hit ? cdb_data : rf_data;
    endfunction

    function automatic IS_EX_PACKET is_ex_from_id(
        input ID_IS_PACKET     p,
        input logic [XLEN-1:0] op1,
        input logic [XLEN-1:0] op2
    );
        IS_EX_PACKET r;
        r                   = '0;
        r.valid             = 1'b1;
        r.inst              = p.inst;
        r.PC                = p.PC;
        r.NPC               = p.NPC;
        r.rs1_value         = op1;
        r.rs2_value         = op2;
        r.opa_select        = p.opa_select;
        r.opb_select        = p.opb_select;
        r.dest_reg_idx      = p.dest_reg.reg_num;
        r.alu_func          = p.alu_func;
        r.rd_mem            = p.rd_mem;
        r.wr_mem            = p.wr_mem;
        r.cond_branch       = p.cond_branch;
        r.uncond_branch     = p.uncond_branch;
        r.halt              = p.halt;
        r.illegal           = p.illegal;
        r.csr_op            = p.csr_op;
        r.function_type     = p.function_type;
        r.rob_index         = p.rob_index;
        r.has_dest          = p.has_dest;
        r.issued_fu_index   = p.issued_fu_index;
        r.arch_dest_reg_num = p.arch_dest_reg_num;
        return r;
    endfunction

endpackage

// File: rtl/issue_lane.sv
// One issue lane: operand capture with CDB bypass, output register to EX
// and the lane's handoff counter.
module issue_lane
    import issue_pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     capture,
    input  logic                     squash,
    input  logic                     ex_ready,
    input  ID_IS_PACKET              id_pkt,
    output logic [PHYS_REG_IDX_SZ:0] rs1_idx,
    output logic [PHYS_REG_IDX_SZ:0] rs2_idx,
    input  logic [XLEN-1:0]          rs1_data,
    input  logic [XLEN-1:0]          rs2_data,
    input  logic                     cdb_valid,
    input  logic [PHYS_REG_IDX_SZ:0] cdb_tag,
    input  logic [XLEN-1:0]          cdb_data,
    output logic                     is_valid,
    output IS_EX_PACKET              is_packet,
    output logic [CNT_W-1:0]         issue_count
);

    logic              valid_q, valid_d;
    IS_EX_PACKET       pkt_q, pkt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              handoff;
    logic [XLEN-1:0]   op1, op2;

    always_comb begin
        rs1_idx = id_pkt.src1_reg.reg_num;
        rs2_idx = id_pkt.src2_reg.reg_num;
        op1     = bypass(cdb_valid, cdb_tag, cdb_data, rs1_idx, rs1_data);
        op2     = bypass(cdb_valid, cdb_tag, cdb_data, rs2_idx, rs2_data);
        handoff = valid_q && ex_ready;

        valid_d = valid_q;
        pkt_d   = pkt_q;
        cnt_d   = cnt_q;

        if (handoff && !squash) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Squash beats capture; a held packet stays put until EX takes it.
        if (squash) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
            pkt_d   = is_ex_from_id(id_pkt, op1, op2);
        end else if (handoff) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        is_packet       = pkt_q;
        is_packet.valid = valid_q;
    end

    assign is_valid    = valid_q;
    assign issue_count = cnt_q;

endmodule

// File: rtl/issue_pipe.sv
// Issue stage top: per-lane ready/capture steering and the halt/squash FSM
// around ISSUE_WIDTH issue_lane instances.
module issue_pipe
    import issue_pipe_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int CNT_W       = 32
) (
    input  logic                                       clock,
    input  logic                                       reset_n,
    input  logic [ISSUE_WIDTH-1:0]                     id_valid,
    input  ID_IS_PACKET [ISSUE_WIDTH-1:0]              id_pkt,
    output logic [ISSUE_WIDTH-1:0]                     id_ready,
    output logic [ISSUE_WIDTH-1:0][PHYS_REG_IDX_SZ:0]  rs1_preg_idx,
    output logic [ISSUE_WIDTH-1:0][PHYS_REG_IDX_SZ:0]  rs2_preg_idx,
    input  logic [ISSUE_WIDTH-1:0][XLEN-1:0]           rs1_preg_data,
    input  logic [ISSUE_WIDTH-1:0][XLEN-1:0]           rs2_preg_data,
    input  logic                                       cdb_valid,
    input  logic [PHYS_REG_IDX_SZ:0]                   cdb_tag,
    input  logic [XLEN-1:0]                            cdb_data,
    input  logic                                       squash,
    input  logic [ISSUE_WIDTH-1:0]                     ex_ready,
    output logic [ISSUE_WIDTH-1:0]                     is_valid,
    output IS_EX_PACKET [ISSUE_WIDTH-1:0]              is_packet,
    output logic                                       halted,
    output logic [ISSUE_WIDTH-1:0][CNT_W-1:0]          issue_count
);

    issue_state_e            state_q;
    logic                    halted_q;
    logic                    run;
    logic                    lane_squash;
    logic                    blocked;
    logic                    halt_cap;
    logic                    halt_out;
    logic [ISSUE_WIDTH-1:0]  capture;

    // Lanes above the first halting lane are dropped so nothing younger
    // than the halt reaches EX.
    always_comb begin
        run         = (state_q == RUN);
        lane_squash = squash && (state_q != HALTED);
        blocked     = 1'b0;
        halt_cap    = 1'b0;
        halt_out    = 1'b0;
        id_ready    = '0;
        capture     = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            id_ready[i] = run && !squash && (!is_valid[i] || ex_ready[i]);
            capture[i]  = id_valid[i] && id_ready[i] && !blocked;
            if (capture[i] && id_pkt[i].halt) begin
                blocked  = 1'b1;
                halt_cap = 1'b1;
            end
            halt_out = halt_out ||
                       (is_valid[i] && ex_ready[i] && is_packet[i].halt);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!squash && halt_cap) begin
                        state_q <= HALT_PEND;
                    end
                end
                HALT_PEND: begin
                    if (squash) begin
                        state_q <= RUN;
                    end else if (halt_out) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q  <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign halted = halted_q;

    for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_lane
        issue_lane #(
            .CNT_W (CNT_W)
        ) u_lane (
            .clock       (clock),
            .reset_n     (reset_n),
            .capture     (capture[g]),
            .squash      (lane_squash),
            .ex_ready    (ex_ready[g]),
            .id_pkt      (id_pkt[g]),
            .rs1_idx     (rs1_preg_idx[g]),
            .rs2_idx     (rs2_preg_idx[g]),
            .rs1_data    (rs1_preg_data[g]),
            .rs2_data    (rs2_preg_data[g]),
            .cdb_valid   (cdb_valid),
            .cdb_tag     (cdb_tag),
            .cdb_data    (cdb_data),
            .is_valid    (is_valid[g]),
            .is_packet   (is_packet[g]),
            .issue_count (issue_count[g])
        );
    end

endmodule

// File: tb/tb_issue_pipe.sv
// Scoreboard bench for issue_pipe: directed vectors push expected EX packets,
// a negedge monitor pops and compares them at every handoff.
module tb_issue_pipe;
    import issue_pipe_pkg::*;

    localparam int W  = 2;
    localparam int CW = 4;

    logic                               clock = 1'b0;
    logic                               reset_n;
    logic [W-1:0]                       id_valid;
    ID_IS_PACKET [W-1:0]                id_pkt;
    logic [W-1:0]                       id_ready;
    logic [W-1:0][PHYS_REG_IDX_SZ:0]    rs1_preg_idx;
    logic [W-1:0][PHYS_REG_IDX_SZ:0]    rs2_preg_idx;
    logic [W-1:0][XLEN-1:0]             rs1_preg_data;
    logic [W-1:0][XLEN-1:0]             rs2_preg_data;
    logic                               cdb_valid;
    logic [PHYS_REG_IDX_SZ:0]           cdb_tag;
    logic [XLEN-1:0]                    cdb_data;
    logic                               squash;
    logic [W-1:0]                       ex_ready;
    logic [W-1:0]                       is_valid;
    IS_EX_PACKET [W-1:0]                is_packet;
    logic                               halted;
    logic [W-1:0][CW-1:0]               issue_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [5:0]  dest;
        logic        halt;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   checks   = 0;
    int   failures = 0;

    issue_pipe #(
        .ISSUE_WIDTH (W),
        .CNT_W       (CW)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .id_valid      (id_valid),
        .id_pkt        (id_pkt),
        .id_ready      (id_ready),
        .rs1_preg_idx  (rs1_preg_idx),
        .rs2_preg_idx  (rs2_preg_idx),
        .rs1_preg_data (rs1_preg_data),
        .rs2_preg_data (rs2_preg_data),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .squash        (squash),
        .ex_ready      (ex_ready),
        .is_valid      (is_valid),
        .is_packet     (is_packet),
        .halted        (halted),
        .issue_count   (issue_count)
    );

    always #5 clock = ~clock;

    function automatic ID_IS_PACKET mk(input logic [31:0] pc,
                                       input logic [5:0] s1,
                                       input logic [5:0] s2,
                                       input logic [5:0] d,
                                       input logic h);
        ID_IS_PACKET p;
        p = '0;
        p.inst = pc | 32'h13;
        p.PC = pc;
        p.NPC = pc + 32'd4;
        p.src1_reg.reg_num = s1;
        p.src2_reg.reg_num = s2;
        p.dest_reg.reg_num = d;
        p.halt = h;
        p.has_dest = 1'b1;
        p.arch_dest_reg_num = d[4:0];
        return p;
    endfunction

    task automatic push(input int lane, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [5:0] d, input logic h);
        exp_t e;
        e.pc = pc;
        e.npc = pc + 32'd4;
        e.inst = pc | 32'h13;
        e.rs1 = r1;
        e.rs2 = r2;
        e.dest = d;
        e.halt = h;
        if (lane == 0) sb0.push_back(e);
        else sb1.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Monitor: a handoff is valid&&ready at the coming edge, not squashed.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            for (int i = 0; i < W; i++) begin
                if (is_valid[i] && ex_ready[i] && !squash) begin
                    exp_t a;
                    exp_t e;
                    a.pc   = is_packet[i].PC;
                    a.npc  = is_packet[i].NPC;
                    a.inst = is_packet[i].inst;
                    a.rs1  = is_packet[i].rs1_value;
                    a.rs2  = is_packet[i].rs2_value;
                    a.dest = is_packet[i].dest_reg_idx;
                    a.halt = is_packet[i].halt;
                    checks++;
                    if ((i == 0 && sb0.size() == 0) ||
                        (i == 1 && sb1.size() == 0)) begin
                        failures++;
                        $display("FAIL sb_lane%0d: unexpected handoff %h",
                                 i, a);
                    end else begin
                        e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                        if (a !== e) begin
                            failures++;
                            $display("FAIL sb_lane%0d: got %h expected %h",
                                     i, a, e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset_n       = 1'b0;
        id_valid      = '0;
        id_pkt        = '0;
        rs1_preg_data = '0;
        rs2_preg_data = '0;
        cdb_valid     = 1'b0;
        cdb_tag       = '0;
        cdb_data      = '0;
        squash        = 1'b0;
        ex_ready      = '0;
        #3;
        chk("rst_valid", 64'(is_valid), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_count", 64'(issue_count), 64'd0);
        chk("rst_pkt", 64'(|is_packet), 64'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        chk("idle_ready", 64'(id_ready), 64'h3);

        // Plain capture from the regfile
        ex_ready         = 2'b11;
        id_pkt[0]        = mk(32'h100, 6'd5, 6'd6, 6'd7, 1'b0);
        rs1_preg_data[0] = 32'h11;
        rs2_preg_data[0] = 32'h22;
        id_valid         = 2'b01;
        #1;
        chk("rs1_idx", 64'(rs1_preg_idx[0]), 64'd5);
        chk("rs2_idx", 64'(rs2_preg_idx[0]), 64'd6);
        push(0, 32'h100, 32'h11, 32'h22, 6'd7, 1'b0);
        step;
        id_valid = '0;
        chk("cap_valid", 64'(is_valid[0]), 64'd1);
        chk("cap_rs1", 64'(is_packet[0].rs1_value), 64'h11);
        step;
        chk("cnt_first", 64'(issue_count[0]), 64'd1);
        chk("ho_clear", 64'(is_valid[0]), 64'd0);

        // CDB bypass hit, miss on tag 0, and no forwarding to reg 0
        cdb_valid = 1'b1;
        cdb_tag   = 6'd5;
        cdb_data  = 32'hAB;
        id_pkt[0] = mk(32'h110, 6'd5, 6'd6, 6'd8, 1'b0);
        id_valid  = 2'b01;
        push(0, 32'h110, 32'hAB, 32'h22, 6'd8, 1'b0);
        step;
        cdb_tag   = 6'd0;
        id_pkt[0] = mk(32'h120, 6'd5, 6'd6, 6'd9, 1'b0);
        push(0, 32'h120, 32'h11, 32'h22, 6'd9, 1'b0);
        step;
        cdb_data         = 32'hCD;
        rs1_preg_data[0] = 32'h33;
        id_pkt[0]        = mk(32'h130, 6'd0, 6'd6, 6'd10, 1'b0);
        push(0, 32'h130, 32'h33, 32'h22, 6'd10, 1'b0);
        step;
        id_valid  = '0;
        cdb_valid = 1'b0;
        step;
        chk("cnt_bypass", 64'(issue_count[0]), 64'd4);

        // Lane 1 stalls three cycles while lane 0 keeps flowing
        id_pkt[0]        = mk(32'h300, 6'd1, 6'd2, 6'd12, 1'b0);
        rs1_preg_data[0] = 32'h77;
        rs2_preg_data[0] = 32'h88;
        id_pkt[1]        = mk(32'h200, 6'd3, 6'd4, 6'd11, 1'b0);
        rs1_preg_data[1] = 32'h55;
        rs2_preg_data[1] = 32'h66;
        ex_ready         = 2'b01;
        id_valid         = 2'b11;
        push(0, 32'h300, 32'h77, 32'h88, 6'd12, 1'b0);
        push(1, 32'h200, 32'h55, 32'h66, 6'd11, 1'b0);
        step;
        for (int k = 0; k < 3; k++) begin
            chk("stall_ready1", 64'(id_ready[1]), 64'd0);
            chk("flow_ready0", 64'(id_ready[0]), 64'd1);
            chk("stall_pc", 64'(is_packet[1].PC), 64'h200);
            chk("stall_rs1", 64'(is_packet[1].rs1_value), 64'h55);
            chk("stall_vld", 64'({is_packet[1].valid, is_valid[1]}), 64'h3);
            id_pkt[0] = mk(32'h310 + 32'(k) * 32'h10, 6'd1, 6'd2, 6'd12,
                           1'b0);
            push(0, 32'h310 + 32'(k) * 32'h10, 32'h77, 32'h88, 6'd12, 1'b0);
            id_pkt[1]        = mk(32'h210, 6'd8, 6'd9, 6'd13, 1'b0);
            rs1_preg_data[1] = 32'h99;
            rs2_preg_data[1] = 32'h9A;
            step;
        end
        ex_ready = 2'b11;
        id_valid = 2'b10;
        push(1, 32'h210, 32'h99, 32'h9A, 6'd13, 1'b0);
        step;
        id_valid = '0;
        step;
        chk("cnt_stall1", 64'(issue_count[1]), 64'd2);
        chk("cnt_stall0", 64'(issue_count[0]), 64'd8);

        // Halt on lane 0 blocks lane 1 in the same cycle
        id_pkt[0] = mk(32'h400, 6'd1, 6'd2, 6'd14, 1'b1);
        id_pkt[1] = mk(32'h410, 6'd1, 6'd2, 6'd15, 1'b0);
        id_valid  = 2'b11;
        ex_ready  = 2'b00;
        push(0, 32'h400, 32'h77, 32'h88, 6'd14, 1'b1);
        step;
        id_valid = '0;
        chk("halt_cap", 64'(is_valid), 64'h1);
        chk("halt_pend", 64'(dut.state_q), 64'(HALT_PEND));
        chk("halt_pend_h", 64'(halted), 64'd0);
        chk("halt_pend_rdy", 64'(id_ready), 64'd0);
        step;
        chk("halt_wait_h", 64'(halted), 64'd0);
        ex_ready = 2'b11;
        step;
        chk("halted", 64'(halted), 64'd1);
        chk("halted_st", 64'(dut.state_q), 64'(HALTED));
        chk("halted_cnt", 64'(issue_count[0]), 64'd9);
        squash   = 1'b1;
        id_valid = 2'b11;
        step;
        squash = 1'b0;
        #1;
        chk("halted_sq", 64'(halted), 64'd1);
        chk("halted_rdy", 64'(id_ready), 64'd0);
        id_valid = '0;

        reset_n = 1'b0;
        #1;
        chk("rst2_halted", 64'(halted), 64'd0);
        chk("rst2_cnt", 64'(issue_count), 64'd0);
        chk("rst2_st", 64'(dut.state_q), 64'(RUN));
        step;
        reset_n = 1'b1;
        step;

        // Squash overriding a capture in RUN
        id_pkt[1] = mk(32'h500, 6'd1, 6'd2, 6'd3, 1'b0);
        id_valid  = 2'b10;
        ex_ready  = 2'b00;
        step;
        chk("sq_pre", 64'(is_valid), 64'h2);
        id_pkt[0] = mk(32'h510, 6'd1, 6'd2, 6'd3, 1'b0);
        id_valid  = 2'b11;
        ex_ready  = 2'b11;
        squash    = 1'b1;
        step;
        squash   = 1'b0;
        id_valid = '0;
        chk("sq_valid", 64'(is_valid), 64'd0);
        chk("sq_cnt", 64'(issue_count), 64'd0);

        // Squash while a halt is pending
        id_pkt[0] = mk(32'h600, 6'd1, 6'd2, 6'd3, 1'b1);
        id_valid  = 2'b01;
        ex_ready  = 2'b00;
        step;
        id_valid = '0;
        chk("sqh_pend", 64'(dut.state_q), 64'(HALT_PEND));
        squash   = 1'b1;
        id_valid = 2'b11;
        ex_ready = 2'b11;
        step;
        squash   = 1'b0;
        id_valid = '0;
        #1;
        chk("sqh_valid", 64'(is_valid), 64'd0);
        chk("sqh_state", 64'(dut.state_q), 64'(RUN));
        chk("sqh_cnt", 64'(issue_count), 64'd0);
        chk("sqh_halted", 64'(halted), 64'd0);
        chk("sqh_ready", 64'(id_ready), 64'h3);

        // Reset in the middle of a stall drops the packet
        id_pkt[0] = mk(32'h700, 6'd1, 6'd2, 6'd3, 1'b0);
        id_valid  = 2'b01;
        ex_ready  = 2'b00;
        step;
        id_valid = '0;
        step;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(is_valid), 64'd0);
        chk("mid_rst_pkt", 64'(|is_packet), 64'd0);
        chk("mid_rst_cnt", 64'(issue_count), 64'd0);
        step;
        reset_n = 1'b1;

        // Counter wrap at all-ones
        ex_ready = 2'b11;
        id_valid = 2'b01;
        for (int k = 0; k < 15; k++) begin
            id_pkt[0] = mk(32'h800 + 32'(k) * 32'h4, 6'd1, 6'd2, 6'd3, 1'b0);
            push(0, 32'h800 + 32'(k) * 32'h4, 32'h77, 32'h88, 6'd3, 1'b0);
            step;
        end
        id_valid = '0;
        step;
        chk("cnt_full", 64'(issue_count[0]), 64'hF);
        id_pkt[0] = mk(32'h900, 6'd1, 6'd2, 6'd3, 1'b0);
        id_valid  = 2'b01;
        push(0, 32'h900, 32'h77, 32'h88, 6'd3, 1'b0);
        step;
        id_valid = '0;
        step;
        chk("cnt_wrap", 64'(issue_count[0]), 64'd0);
        chk("cnt_lane1", 64'(issue_count[1]), 64'd0);

        step;
        chk("sb0_empty", 64'(sb0.size()), 64'd0);
        chk("sb1_empty", 64'(sb1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/issue_pipe.md
ISSUE_PIPE -- requirements
Module: issue_pipe

Interface
REQ-001 SHALL have parameter ISSUE_WIDTH, default 2: number of independent issue lanes (1..4).
REQ-002 SHALL have parameter CNT_W, default 32: width of each per-lane issue counter.
REQ-003 SHALL have port clock  in  1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port id_valid  in  ISSUE_WIDTH: per-lane packet valid from ID.
REQ-006 SHALL have port id_pkt  in  ISSUE_WIDTH x ID_IS_PACKET: per-lane input packets.
REQ-007 SHALL have port id_ready  out  ISSUE_WIDTH: per-lane accept.
REQ-008 SHALL have ports rs1_preg_idx and rs2_preg_idx  out  ISSUE_WIDTH x (PHYS_REG_IDX_SZ+1): regfile read indices, driven from id_pkt src1_reg/src2_reg reg_num.
REQ-009 SHALL have ports rs1_preg_data and rs2_preg_data  in  ISSUE_WIDTH x XLEN: regfile read data, same cycle.
REQ-010 SHALL have ports cdb_valid  in  1, cdb_tag  in  PHYS_REG_IDX_SZ+1, and cdb_data  in  XLEN: broadcast result being written this cycle.
REQ-011 SHALL have port squash  in  1: flush all in-flight issue state.
REQ-012 SHALL have port ex_ready  in  ISSUE_WIDTH: per-lane EX accept.
REQ-013 SHALL have ports is_valid  out  ISSUE_WIDTH and is_packet  out  ISSUE_WIDTH x IS_EX_PACKET: registered output to EX.
REQ-014 SHALL have port halted  out  1: high once a halt instruction has been handed to EX.
REQ-015 SHALL have port issue_count  out  ISSUE_WIDTH x CNT_W: per-lane handoff counters.

Function
REQ-016 SHALL drive id_ready[i] = (state==RUN) && !squash && (!is_valid[i] || ex_ready[i]).
REQ-017 SHALL capture lane i into its output register at the edge where id_valid[i] && id_ready[i]; latency is exactly 1 cycle.
REQ-018 SHALL set operand k to cdb_data when cdb_valid && cdb_tag==src_k reg_num && reg_num!=0 at capture; otherwise it SHALL use rsk_preg_data.
REQ-019 SHALL copy every other IS_EX_PACKET field unchanged from id_pkt: inst, PC, NPC, opa/opb_select, dest_reg_idx (= dest_reg.reg_num), alu_func, rd_mem, wr_mem, cond/uncond_branch, halt, illegal, csr_op, function_type, rob_index, has_dest, issued_fu_index, arch_dest_reg_num.
REQ-020 SHALL set is_packet[i].valid equal to is_valid[i].
REQ-021 SHALL hold is_packet[i] and is_valid[i] stable while is_valid[i] && !ex_ready[i].
REQ-022 SHALL clear is_valid[i] after a handoff (is_valid[i] && ex_ready[i]) with no new capture on that lane.
REQ-023 SHALL implement the states RUN, HALT_PEND and HALTED.
REQ-024 SHALL transition RUN -> HALT_PEND when any captured packet has halt=1; lanes with a higher index than the lowest halting lane in that cycle SHALL NOT be captured.
REQ-025 SHALL transition HALT_PEND -> HALTED at the handoff of the halt packet; halted SHALL be 1 in HALTED only.
REQ-026 SHALL, on squash in RUN or HALT_PEND, clear all is_valid bits at the next edge, override any capture, and return to RUN.
REQ-027 SHALL ignore squash in HALTED; HALTED SHALL be exited only by reset.
REQ-028 SHALL increment issue_count[i] by 1 on each lane-i handoff when squash=0, wrapping modulo 2^CNT_W.

Reset
REQ-029 SHALL, while reset_n=0, force is_valid=0, all is_packet fields=0, state=RUN, halted=0 and issue_count=0 without waiting for a clock edge.
REQ-030 SHALL resume normal operation at the first rising edge after reset_n deasserts; any packet in flight at reset SHALL be lost.

Structure
REQ-031 SHALL take ID_IS_PACKET, IS_EX_PACKET, XLEN and PHYS_REG_IDX_SZ from the shared package, and SHALL add the issue-state enum to that package.
REQ-032 SHALL place per-lane capture, bypass and counter logic in one sub-module, issue_lane, instantiated ISSUE_WIDTH times; the state machine SHALL remain in the top level.

Verification
REQ-033 Bench SHALL cover: lane0 valid with src1=5 and preg data 0x11, ex_ready=1 -> next cycle is_valid[0]=1, rs1_value=0x11, issue_count[0]=1 one cycle later.
REQ-034 Bench SHALL cover: same stimulus plus cdb_valid=1, cdb_tag=5, cdb_data=0xAB -> rs1_value=0xAB; with tag=0 instead, data is taken from preg.
REQ-035 Bench SHALL cover: ex_ready[1]=0 for 3 cycles -> id_ready[1]=0 and is_packet[1] unchanged for those cycles while lane0 continues to flow.
REQ-036 Bench SHALL cover: lane0 halt and lane1 valid in the same cycle -> only lane0 is captured, state is HALT_PEND, and halted=1 the cycle after handoff, with id_ready=0 thereafter.
REQ-037 Bench SHALL cover: squash asserted together with a capture and a pending halt -> is_valid=0 next cycle, state=RUN, no counter increment.
REQ-038 Bench SHALL cover: reset_n pulsed low mid-stall -> outputs zero immediately; issue_count preset to 0xFFFFFFFF wraps to 0 on the next handoff.
